// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, functs, ALU codes,
// datapath mux selects and the FSM state set.
package mc_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_LUI  = 3'd4;

  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_4       = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_A      = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXE_R   = 4'd6,
    S_R_WB    = 4'd7,
    S_EXE_I   = 4'd8,
    S_I_WB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13
  } state_e;

  // Successor of DECODE; S_FETCH here means the instruction is unsupported.
  function automatic state_e decode_target(input logic [5:0] op, input logic [5:0] funct);
    state_e nxt;
    nxt = S_FETCH;
    case (op)
      OP_LW, OP_SW:   nxt = S_MEM_ADR;
      OP_ORI, OP_LUI: nxt = S_EXE_I;
      OP_BEQ:         nxt = S_BRANCH;
      OP_J:           nxt = S_JUMP;
      OP_JAL:         nxt = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLT: nxt = S_EXE_R;
          FN_JR:                    nxt = S_JR;
          default:                  nxt = S_FETCH;
        endcase
      end
      default:        nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_op_decode.sv
// ALU operation select: a function of state, plus funct in EXE_R and op in EXE_I.
module alu_op_decode
  import mc_control_unit_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] funct,
  input  logic [5:0] op,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves alu_ctrl unassigned (no latch).
    alu_ctrl = ALU_ADD;
    case (state)
      S_EXE_R: begin
        case (funct)
          FN_SUBU: alu_ctrl = ALU_SUB;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_EXE_I:  alu_ctrl = (op == OP_LUI) ? ALU_LUI : ALU_OR;
      S_BRANCH: alu_ctrl = ALU_SUB;
      default:  alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle main controller: state register, next-state logic and Moore output
// decode for the datapath; reset forces every enable low in the same cycle.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_ctrl,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic       instr_done
);

  logic [STATE_W-1:0] state_q;
  state_e             state;
  state_e             state_d;
  state_e             decode_nxt;
  logic [2:0]         alu_ctrl_dec;

  assign state      = state_e'(state_q);
  assign decode_nxt = decode_target(op, funct);

  always_comb begin
    state_d = S_FETCH;
    case (state)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = decode_nxt;
      S_MEM_ADR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_d = S_MEM_WB;
      S_EXE_R:   state_d = S_R_WB;
      S_EXE_I:   state_d = S_I_WB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
    if (rst) state_q <= STATE_W'(S_FETCH);
    else     state_q <= STATE_W'(state_d);
  end

  alu_op_decode u_alu_op_decode (
    .state    (state),
    .funct    (funct),
    .op       (op),
    .alu_ctrl (alu_ctrl_dec)
  );

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_B;
    ext_op     = 1'b0;
    alu_ctrl   = rst ? ALU_ADD : alu_ctrl_dec;
    reg_dst    = RDST_RT;
    mem_to_reg = M2R_ALUOUT;
    pc_src     = PCS_ALU;
    illegal    = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ir_wr     = 1'b1;
          pc_wr     = 1'b1;
          alu_src_b = ASB_4;
        end
        S_DECODE: begin
          alu_src_b = ASB_IMM_SH2;
          ext_op    = 1'b1;
          if (decode_nxt == S_FETCH) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
          ext_op    = 1'b1;
        end
        S_MEM_WB: begin
          reg_wr     = 1'b1;
          mem_to_reg = M2R_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr     = 1'b1;
          instr_done = 1'b1;
        end
        S_EXE_R:  alu_src_a = 1'b1;
        S_R_WB: begin
          reg_wr     = 1'b1;
          reg_dst    = RDST_RD;
          instr_done = 1'b1;
        end
        S_EXE_I: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
        end
        S_I_WB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          pc_src     = PCS_ALUOUT;
          pc_wr      = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PCS_JUMP;
          pc_wr      = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          pc_src     = PCS_JUMP;
          pc_wr      = 1'b1;
          reg_wr     = 1'b1;
          reg_dst    = RDST_RA;
          mem_to_reg = M2R_PC;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_src     = PCS_A;
          pc_wr      = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench: per-instruction expected control sequences built from the
// instruction-level behaviour, compared cycle by cycle against the controller.
module tb_mc_control_unit;
  import mc_control_unit_pkg::ALU_ADD;
  import mc_control_unit_pkg::ALU_SUB;
  import mc_control_unit_pkg::ALU_OR;
  import mc_control_unit_pkg::ALU_SLT;
  import mc_control_unit_pkg::ALU_LUI;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       mem_wr;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_ctrl;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       pc_wr, ir_wr, mem_wr, reg_wr, alu_src_a, ext_op, illegal, instr_done;
  logic [1:0] alu_src_b, reg_dst, mem_to_reg, pc_src;
  logic [2:0] alu_ctrl;
  ctrl_t      got;
  ctrl_t      exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_wr(mem_wr), .reg_wr(reg_wr),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .illegal(illegal), .instr_done(instr_done)
  );

  assign got = {pc_wr, ir_wr, mem_wr, reg_wr, alu_src_a, alu_src_b, ext_op, alu_ctrl,
                reg_dst, mem_to_reg, pc_src, illegal, instr_done};

  function automatic bit supported(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return (f == 6'h21) || (f == 6'h23) || (f == 6'h2A) || (f == 6'h08);
    return (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) || (o == 6'h02) ||
           (o == 6'h03) || (o == 6'h0D) || (o == 6'h0F);
  endfunction

  // Expected control vector for every cycle of one instruction, FETCH first.
  task automatic build_expected(input logic [5:0] o, input logic [5:0] f, input logic z);
    ctrl_t c;
    exp_q.delete();
    c = '0; c.ir_wr = 1; c.pc_wr = 1; c.alu_src_b = 2'b01; c.alu_ctrl = ALU_ADD;
    exp_q.push_back(c);
    c = '0; c.alu_src_b = 2'b11; c.ext_op = 1; c.alu_ctrl = ALU_ADD;
    if (!supported(o, f)) begin
      c.illegal = 1; c.instr_done = 1;
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    c = '0;
    if (o == 6'h23 || o == 6'h2B) begin
      c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 1; c.alu_ctrl = ALU_ADD;
      exp_q.push_back(c);
      c = '0;
      if (o == 6'h23) begin
        exp_q.push_back(c);
        c.reg_wr = 1; c.mem_to_reg = 2'b01; c.instr_done = 1;
      end else begin
        c.mem_wr = 1; c.instr_done = 1;
      end
      exp_q.push_back(c);
    end else if (o == 6'h00 && f == 6'h08) begin
      c.pc_src = 2'b11; c.pc_wr = 1; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'h00) begin
      c.alu_src_a = 1;
      c.alu_ctrl = (f == 6'h23) ? ALU_SUB : (f == 6'h2A) ? ALU_SLT : ALU_ADD;
      exp_q.push_back(c);
      c = '0; c.reg_wr = 1; c.reg_dst = 2'b01; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'h0D || o == 6'h0F) begin
      c.alu_src_a = 1; c.alu_src_b = 2'b10;
      c.alu_ctrl = (o == 6'h0F) ? ALU_LUI : ALU_OR;
      exp_q.push_back(c);
      c = '0; c.reg_wr = 1; c.instr_done = 1;
      exp_q.push_back(c);
    end else if (o == 6'h04) begin
      c.alu_src_a = 1; c.alu_ctrl = ALU_SUB; c.pc_src = 2'b01; c.pc_wr = z; c.instr_done = 1;
      exp_q.push_back(c);
    end else begin
      c.pc_src = 2'b10; c.pc_wr = 1; c.instr_done = 1;
      if (o == 6'h03) begin
        c.reg_wr = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      end
      exp_q.push_back(c);
    end
  endtask

  // Entered just after a rising edge with the controller in FETCH; runs `ncyc`
  // cycles of the instruction (0 = all of them) and leaves just after an edge.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int ncyc);
    int last;
    build_expected(o, f, z);
    op = o; funct = f; zero = z;
    last = (ncyc == 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < last; i++) begin
      @(negedge clk);
      n_tests++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s op=%h funct=%h cycle %0d: got %b expected %b", name, o, f, i + 1,
                 got, exp_q[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (got !== ctrl_t'(0)) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, got, ctrl_t'(0));
      end
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_lw();
    run_instr("lw", 6'h23, 6'h15, 1'b0, 0);
  endtask

  task automatic test_rtype();
    run_instr("addu", 6'h00, 6'h21, 1'b0, 0);
    run_instr("subu", 6'h00, 6'h23, 1'b1, 0);
    run_instr("slt", 6'h00, 6'h2A, 1'b0, 0);
    run_instr("jr", 6'h00, 6'h08, 1'b0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0);
    run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 0);
  endtask

  task automatic test_jumps();
    run_instr("j", 6'h02, 6'h3F, 1'b0, 0);
    run_instr("jal", 6'h03, 6'h00, 1'b1, 0);
  endtask

  task automatic test_itype();
    run_instr("ori", 6'h0D, 6'h00, 1'b0, 0);
    run_instr("lui", 6'h0F, 6'h2A, 1'b0, 0);
    run_instr("sw", 6'h2B, 6'h00, 1'b0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'h3F, 6'h00, 1'b0, 0);
    run_instr("illegal_funct", 6'h00, 6'h20, 1'b0, 0);
  endtask

  // Reset asserted while sw sits in MEM_WR: no store, then a clean FETCH.
  task automatic test_reset_mid();
    run_instr("sw_pre_reset", 6'h2B, 6'h00, 1'b0, 3);
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (got !== ctrl_t'(0)) begin
        n_fail++;
        $display("FAIL reset_in_mem_wr cycle %0d: got %b expected %b", i, got, ctrl_t'(0));
      end
      @(posedge clk); #1;
    end
    rst = 0;
    run_instr("after_reset", 6'h0D, 6'h00, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] o, f;
    logic       z;
    for (int n = 0; n < 60; n++) begin
      f = 6'($urandom_range(0, 63));
      z = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
        0:  o = 6'h23;
        1:  o = 6'h2B;
        2:  begin o = 6'h00; f = 6'h21; end
        3:  begin o = 6'h00; f = 6'h23; end
        4:  begin o = 6'h00; f = 6'h2A; end
        5:  begin o = 6'h00; f = 6'h08; end
        6:  o = 6'h0D;
        7:  o = 6'h0F;
        8:  o = 6'h04;
        9:  o = 6'h02;
        10: o = 6'h03;
        default: begin
          do begin
            o = 6'($urandom_range(0, 63));
            f = 6'($urandom_range(0, 63));
          end while (supported(o, f));
        end
      endcase
      run_instr("random", o, f, z, 0);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jumps();
    test_itype();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
